// File: rtl/seq_group_checker_pkg.sv
// ============================================================================
// Module  : seq_group_checker_pkg
// Purpose : Shared definitions for the Sudoku group checker: FSM state
//           encodings, default group size / digit width, and board-size
//           constants shared with the board-memory scanner.
// Ports   : none (package)
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package seq_group_checker_pkg;

  // FSM state encodings (kept as plain 2-bit constants so legacy blocks
  // that compare raw state values stay compatible).
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_COLLECT = 2'd1;
  localparam logic [1:0] ST_DONE    = 2'd2;

  // Default group size and digit width.
  localparam int N_DEFAULT  = 4;
  localparam int DW_DEFAULT = 4;

  // Board sizes served by this checker; shared with the scanner.
  localparam int BOARD_SMALL = 4;
  localparam int BOARD_LARGE = 9;

endpackage : seq_group_checker_pkg

`default_nettype wire

// File: rtl/group_onehot_decode.sv
// ============================================================================
// Module  : group_onehot_decode
// Purpose : Purely combinational decode of one Sudoku digit into an N-bit
//           one-hot vector (bit d-1 set for digit d) plus a legal flag.
//           Illegal digits (0 or > N) produce an all-zero one-hot vector.
// Ports   : digit_i   [DW-1:0]  digit value, 0 = empty cell
//           onehot_o  [N-1:0]   one-hot position of a legal digit
//           legal_o             digit lies in 1..N
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module group_onehot_decode
  import seq_group_checker_pkg::*;
#(
  parameter int N  = N_DEFAULT,
  parameter int DW = DW_DEFAULT
) (
  input  logic [DW-1:0] digit_i,
  output logic [N-1:0]  onehot_o,
  output logic          legal_o
);

  // Upper bound expressed at digit width so the compare is DW bits wide.
  localparam logic [DW-1:0] NMAX = DW'(N);

  always_comb begin
    legal_o = (digit_i != '0) && (digit_i <= NMAX);
    // Matching each bit position against its own digit value avoids ever
    // forming digit-1, so a zero digit cannot underflow into the bitmap.
    for (int i = 0; i < N; i++) begin
      onehot_o[i] = legal_o && (digit_i == DW'(i + 1));
    end
  end

endmodule : group_onehot_decode

`default_nettype wire

// File: rtl/seq_group_checker.sv
// ============================================================================
// Module  : seq_group_checker
// Purpose : Sequential Sudoku group checker. Consumes exactly N digits of one
//           group (row, column or box) over a valid/ready handshake and
//           reports whether they form a permutation of 1..N, with separate
//           duplicate and out-of-range flags.
// Ports   : clk              clock, rising edge
//           rst              synchronous active-high reset
//           start_i          begin a new group (accepted in any state)
//           digit_valid_i    a digit is presented on digit_i
//           digit_i [DW-1:0] digit value, 0 = empty cell
//           digit_ready_o    block accepts a digit this cycle
//           done_o           one-cycle pulse, verdict valid
//           group_correct_o  group is a permutation of 1..N
//           dup_found_o      a legal value appeared more than once
//           range_err_o      a digit was 0 or greater than N
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module seq_group_checker
  import seq_group_checker_pkg::*;
#(
  parameter int N  = N_DEFAULT,
  parameter int DW = DW_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start_i,
  input  logic          digit_valid_i,
  input  logic [DW-1:0] digit_i,
  output logic          digit_ready_o,
  output logic          done_o,
  output logic          group_correct_o,
  output logic          dup_found_o,
  output logic          range_err_o
);

  localparam int CW = $clog2(N + 1);

  // Reject parameter sets that cannot represent every legal digit.
  if (N < 2 || N > 15 || (1 << DW) <= N) begin : g_param_check
    $error("seq_group_checker: need 2 <= N <= 15 and 2**DW > N");
  end

  logic [1:0]    state_q,   state_d;
  logic [N-1:0]  seen_q,    seen_d;
  logic [CW-1:0] count_q,   count_d;
  logic          dup_acc_q, dup_acc_d;
  logic          rng_acc_q, rng_acc_d;

  logic          ready_q;
  logic          done_q;
  logic          correct_q;
  logic          dup_q;
  logic          rng_q;

  logic [N-1:0]  dec_onehot;
  logic          dec_legal;
  logic          xfer;

  group_onehot_decode #(
    .N  (N),
    .DW (DW)
  ) u_decode (
    .digit_i  (digit_i),
    .onehot_o (dec_onehot),
    .legal_o  (dec_legal)
  );

  assign xfer = digit_valid_i && ready_q;

  always_comb begin
    state_d   = state_q;
    seen_d    = seen_q;
    count_d   = count_q;
    dup_acc_d = dup_acc_q;
    rng_acc_d = rng_acc_q;

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d   = ST_COLLECT;
          seen_d    = '0;
          count_d   = '0;
          dup_acc_d = 1'b0;
          rng_acc_d = 1'b0;
        end
      end

      ST_COLLECT: begin
        if (start_i) begin
          // Abort: any digit offered in the same cycle is dropped.
          seen_d    = '0;
          count_d   = '0;
          dup_acc_d = 1'b0;
          rng_acc_d = 1'b0;
        end else if (xfer) begin
          count_d = count_q + CW'(1);
          if (!dec_legal) begin
            rng_acc_d = 1'b1;
          end else begin
            if (|(seen_q & dec_onehot)) begin
              dup_acc_d = 1'b1;
            end
            seen_d = seen_q | dec_onehot;
          end
          // Errors never shorten the group: always N transfers.
          if (count_q == CW'(N - 1)) begin
            state_d = ST_DONE;
          end
        end
      end

      ST_DONE: begin
        if (start_i) begin
          state_d   = ST_COLLECT;
          seen_d    = '0;
          count_d   = '0;
          dup_acc_d = 1'b0;
          rng_acc_d = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      seen_q    <= '0;
      count_q   <= '0;
      dup_acc_q <= 1'b0;
      rng_acc_q <= 1'b0;
      ready_q   <= 1'b0;
      done_q    <= 1'b0;
      correct_q <= 1'b0;
      dup_q     <= 1'b0;
      rng_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      seen_q    <= seen_d;
      count_q   <= count_d;
      dup_acc_q <= dup_acc_d;
      rng_acc_q <= rng_acc_d;
      // Handshake and pulse outputs are registered copies of the next
      // state, so they never depend combinationally on digit_valid_i.
      ready_q   <= (state_d == ST_COLLECT);
      done_q    <= (state_d == ST_DONE);
      // The verdict is captured on entry to DONE and then held.
      if (state_d == ST_DONE) begin
        correct_q <= !dup_acc_d && !rng_acc_d && (&seen_d);
        dup_q     <= dup_acc_d;
        rng_q     <= rng_acc_d;
      end
    end
  end

  assign digit_ready_o   = ready_q;
  assign done_o          = done_q;
  assign group_correct_o = correct_q;
  assign dup_found_o     = dup_q;
  assign range_err_o     = rng_q;

endmodule : seq_group_checker

`default_nettype wire
